// File: rtl/auto_turn_seq_if.sv
// Command/handshake bundle between the semi-auto driving FSM and auto_turn_seq.
// master drives the requests; slave is the sequencer.
interface auto_turn_seq_if;
  logic tick_ms;
  logic start;
  logic dir;
  logic abort;
  logic turn_l;
  logic turn_r;
  logic move_fwd;
  logic busy;
  logic finish;

  modport master (
    output tick_ms, start, dir, abort,
    input  turn_l, turn_r, move_fwd, busy, finish
  );

  modport slave (
    input  tick_ms, start, dir, abort,
    output turn_l, turn_r, move_fwd, busy, finish
  );
endinterface

// File: rtl/auto_turn_seq.sv
// Timed turn sequencer: TURN for TURN_MS ticks, optional forward CRAWL, one-cycle DONE.
// Define AUTO_TURN_CRAWL_EN to include the CRAWL phase; otherwise TURN expiry goes to DONE.
module auto_turn_seq #(
  parameter int unsigned TURN_MS  = 900,
  parameter int unsigned CRAWL_MS = 300
) (
  input logic            sys_clk,
  input logic            rst,
  auto_turn_seq_if.slave bus
);

  if (TURN_MS < 1 || TURN_MS > 65535) begin : g_bad_turn_ms
    $error("auto_turn_seq: TURN_MS out of range 1..65535");
  end
  if (CRAWL_MS < 1 || CRAWL_MS > 65535) begin : g_bad_crawl_ms
    $error("auto_turn_seq: CRAWL_MS out of range 1..65535");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StTurn  = 2'd1;
  localparam logic [1:0] StDone  = 2'd3;
  localparam logic [15:0] TurnLast = 16'(TURN_MS - 1);
`ifdef AUTO_TURN_CRAWL_EN
  localparam logic [1:0] StCrawl = 2'd2;
  localparam logic [15:0] CrawlLast = 16'(CRAWL_MS - 1);
`endif

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        dir_q, dir_d;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    // abort wins over start and over counter expiry
    if (bus.abort) begin
      state_d = StIdle;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            dir_d   = bus.dir;
            cnt_d   = 16'd0;
            state_d = StTurn;
          end
        end
        StTurn: begin
          if (bus.tick_ms) begin
            if (cnt_q == TurnLast) begin
              cnt_d   = 16'd0;
`ifdef AUTO_TURN_CRAWL_EN
              state_d = StCrawl;
`else
              state_d = StDone;
`endif
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
`ifdef AUTO_TURN_CRAWL_EN
        StCrawl: begin
          if (bus.tick_ms) begin
            if (cnt_q == CrawlLast) begin
              cnt_d   = 16'd0;
              state_d = StDone;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
`endif
        StDone: begin
          cnt_d   = 16'd0;
          state_d = StIdle;
        end
        default: begin
          cnt_d   = 16'd0;
          state_d = StIdle;
        end
      endcase
    end
  end

  // Moore outputs: decoded from registered state only
  assign bus.turn_l = (state_q == StTurn) & ~dir_q;
  assign bus.turn_r = (state_q == StTurn) & dir_q;
`ifdef AUTO_TURN_CRAWL_EN
  assign bus.move_fwd = (state_q == StCrawl);
`else
  assign bus.move_fwd = 1'b0;
`endif
  assign bus.finish = (state_q == StDone);
  assign bus.busy   = (state_q != StIdle);

endmodule

// File: tb/tb_auto_turn_seq.sv
// Directed bench for auto_turn_seq (TURN_MS=4, CRAWL_MS=2, tick every 3rd cycle).
// Expectations follow AUTO_TURN_CRAWL_EN when it is defined for the build.
module tb_auto_turn_seq;

  logic sys_clk = 1'b0;
  logic rst     = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   fin_cnt = 0;
  int   exp_fin = 0;

  auto_turn_seq_if bus ();

  auto_turn_seq #(
    .TURN_MS (4),
    .CRAWL_MS(2)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // {turn_l, turn_r, move_fwd, busy, finish}
  localparam logic [4:0] OIdle  = 5'b00000;
  localparam logic [4:0] OLeft  = 5'b10010;
  localparam logic [4:0] ORight = 5'b01010;
  localparam logic [4:0] OCrawl = 5'b00110;
  localparam logic [4:0] ODone  = 5'b00011;

  always @(negedge sys_clk) begin
    if (bus.finish) fin_cnt++;
    n_tests++;
    assert (!(bus.turn_l && bus.turn_r))
    else begin
      n_fail++;
      $error("FAIL turn_excl: turn_l=%b turn_r=%b, required not both 1", bus.turn_l, bus.turn_r);
    end
  end

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bus.turn_l, bus.turn_r, bus.move_fwd, bus.busy, bus.finish};
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: outputs=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_fin(input string tag);
    n_tests++;
    assert (fin_cnt === exp_fin)
    else begin
      n_fail++;
      $error("FAIL %s: finish pulses=%0d required=%0d", tag, fin_cnt, exp_fin);
    end
  endtask

  // Drive one cycle's inputs, let one rising edge pass, return at the falling edge.
  task automatic cyc(input logic s, input logic d, input logic a, input logic t);
    bus.start   = s;
    bus.dir     = d;
    bus.abort   = a;
    bus.tick_ms = t;
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.tick_ms = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // Entered right after the 4th TURN tick.
  task automatic tail(input string tag);
`ifdef AUTO_TURN_CRAWL_EN
    chk({tag, "_crawl0"}, OCrawl);
    run_ticks(1);
    chk({tag, "_crawl1"}, OCrawl);
    run_ticks(1);
`endif
    chk({tag, "_done"}, ODone);
    exp_fin++;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);  // start during DONE is ignored
    chk({tag, "_idle"}, OIdle);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk({tag, "_still_idle"}, OIdle);
    chk_fin({tag, "_fin_cnt"});
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.dir     = 1'b0;
    bus.abort   = 1'b0;
    bus.tick_ms = 1'b0;
    @(negedge sys_clk);

    // Reset holds everything at zero even with requests present
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("reset_hold", OIdle);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_reset_idle", OIdle);

    // Left turn, full sequence
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("left_start", OLeft);
    run_ticks(3);
    chk("left_tick3", OLeft);
    run_ticks(1);
    tail("left");

    // Right turn; a second start mid-turn must not change direction
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("right_start", ORight);
    run_ticks(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("right_restart_ignored", ORight);
    run_ticks(2);
    chk("right_tick3", ORight);
    run_ticks(1);
    tail("right");

    // Abort on the second TURN tick, together with that tick
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_start", OLeft);
    run_ticks(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("abort_idle", OIdle);
    run_ticks(4);
    chk_fin("abort_no_finish");
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("abort_restart", ORight);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("abort_again", OIdle);

    // start and abort together in IDLE
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("start_abort_idle", OIdle);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("start_abort_idle2", OIdle);

    // Asynchronous reset mid-sequence
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_seq_start", OLeft);
`ifdef AUTO_TURN_CRAWL_EN
    run_ticks(5);
    chk("rst_in_crawl", OCrawl);
`else
    run_ticks(2);
    chk("rst_in_turn", OLeft);
`endif
    #2 rst = 1'b0;
    #1 chk("rst_async", OIdle);
    @(negedge sys_clk);
    rst = 1'b1;
    run_ticks(5);
    chk("rst_stays_idle", OIdle);
    chk_fin("rst_no_finish");
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_fresh_start", OLeft);
    run_ticks(4);
    tail("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/auto_turn_seq.md
AUTO_TURN_SEQ -- requirements
Module: auto_turn_seq

Interface
REQ-001 Parameter TURN_MS, default 900: number of tick_ms ticks the turn phase lasts; legal range 1..65535.
REQ-002 Parameter CRAWL_MS, default 300: number of tick_ms ticks the post-turn forward crawl lasts; legal range 1..65535.
REQ-003 sys_clk  input  1  100 MHz system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 tick_ms  input  1  one-sys_clk-wide enable, once per millisecond, synchronous to sys_clk.
REQ-006 start  input  1  one-cycle request pulse issued when the driving FSM enters its semi-auto turning state.
REQ-007 dir  input  1  turn direction: 0 = left, 1 = right; sampled only with an accepted start.
REQ-008 abort  input  1  level; cancels any sequence in progress (power-off or mode exit).
REQ-009 turn_l  output  1  left-turn command to the UART command byte.
REQ-010 turn_r  output  1  right-turn command to the UART command byte.
REQ-011 move_fwd  output  1  forward command during the crawl phase.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 finish  output  1  one-cycle pulse marking sequence completion.

Function
REQ-014 The block SHALL implement a Moore FSM with states IDLE, TURN, CRAWL and DONE, using a 16-bit tick counter cnt and a direction register dir_q.
REQ-015 In IDLE, when start=1 and abort=0, the block SHALL latch dir into dir_q, clear cnt and enter TURN on the same edge.
REQ-016 A start that arrives while busy=1 SHALL be ignored, and dir_q SHALL remain unchanged.
REQ-017 In TURN, cnt SHALL increment only on cycles with tick_ms=1.
REQ-018 In TURN, on a tick_ms cycle with cnt==TURN_MS-1, the block SHALL clear cnt and enter CRAWL.
REQ-019 In CRAWL, on a tick_ms cycle with cnt==CRAWL_MS-1, the block SHALL enter DONE.
REQ-020 DONE SHALL last exactly one sys_clk cycle, after which the block SHALL return to IDLE unconditionally.
REQ-021 A start in the DONE cycle SHALL be ignored.
REQ-022 Outputs SHALL decode from the state register only:
  - turn_l = TURN & ~dir_q
  - turn_r = TURN & dir_q
  - move_fwd = CRAWL
  - finish = DONE
  - busy = ~IDLE
REQ-023 turn_l and turn_r SHALL never be high together.
REQ-024 abort=1 SHALL force IDLE on the next edge from any state, clear cnt and produce no finish pulse.
REQ-025 abort SHALL take priority over both start and counter expiry in the same cycle.
REQ-026 With tick_ms held low, the FSM SHALL hold its current state indefinitely, except DONE, which always exits.
REQ-027 cnt SHALL never wrap; it is cleared on every phase change.

Reset
REQ-028 While rst=0, state SHALL be IDLE, cnt SHALL be 0, dir_q SHALL be 0, and all outputs SHALL be 0.
REQ-029 Assertion of rst mid-sequence SHALL take effect immediately, without waiting for a clock edge, and SHALL produce no finish pulse.
REQ-030 After rst deasserts, the first start SHALL be accepted normally.

Configuration
REQ-031 With macro AUTO_TURN_CRAWL_EN defined, the block SHALL include the CRAWL phase exactly as specified above.
REQ-032 Without AUTO_TURN_CRAWL_EN, CRAWL SHALL not exist:
  - TURN expiry (REQ-018) SHALL enter DONE directly.
  - move_fwd SHALL be tied to 0.
  - CRAWL_MS SHALL be unused.

Verification
REQ-033 TURN_MS=4, CRAWL_MS=2, CRAWL_EN defined, tick_ms every 3rd cycle, start with dir=0 -> turn_l high for exactly 4 ticks, then move_fwd high for 2 ticks, then finish high for 1 cycle, then busy=0; turn_r stays 0 throughout.
REQ-034 Same setup with dir=1, and a second start with dir=0 issued during TURN -> turn_r drives the whole turn phase; the second start has no effect.
REQ-035 abort asserted at tick 2 of TURN -> all outputs 0 on the next cycle; finish never pulses; a new start is then accepted.
REQ-036 rst pulled low during CRAWL -> outputs 0 within the same cycle; the sequence restarts only on a fresh start.
REQ-037 CRAWL_EN undefined, TURN_MS=3 -> finish pulses on the cycle after the 3rd tick; move_fwd is never 1.
REQ-038 start and abort asserted in the same IDLE cycle -> the block remains IDLE and busy stays 0.
